fft_frame_packetizer: RTL
=========================

Name: fft_frame_packetizer

Overview:
- Sits directly downstream of the 36-bit timing-adapter FIFO in the FFT datapath.
- Consumes a raw valid/ready sample stream of packed complex words (18-bit real, 18-bit imag) and emits Avalon-ST packets of exactly FRAME_LEN samples with startofpacket/endofpacket markers for the FFT core.
- A flush request closes a partial frame by zero-padding it to full length, so the FFT never stalls waiting for a frame that will not be completed.

Parameters:
- DATA_WIDTH, 36, sample width {real[35:18], imag[17:0]}.
- FRAME_LEN, 64, samples per packet; legal range 2..2^IDX_WIDTH.
- IDX_WIDTH, 6, width of the in-frame sample index counter.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  synchronous, active-low reset.
- in_ready  output  1  sink ready to FIFO.
- in_valid  input  1  source valid from FIFO.
- in_data  input  DATA_WIDTH  sample from FIFO.
- out_ready  input  1  FFT core ready.
- out_valid  output  1  packet data valid.
- out_data  output  DATA_WIDTH  sample or zero pad.
- out_sop  output  1  first sample of frame.
- out_eop  output  1  last sample of frame.
- flush  input  1  single-cycle request to close the current partial frame.
- pad_active  output  1  high while zero-padding is in progress.

Behaviour:
- Reset is synchronous on the rising clk edge while reset_n=0. Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, pad_active=0, idx=0, state=STREAM. in_ready is combinational and reads 1 after reset.
- A reset mid-frame discards the partial frame. No eop is generated. The next accepted sample is sop.
- Output stage: a single register stage, so latency from input acceptance to out_valid is 1 cycle. out_* holds stable while out_valid=1 and out_ready=0.
- Load condition: ld = !out_valid || out_ready.
- State STREAM:
  - in_ready = ld.
  - On in_valid && in_ready: out_data=in_data, out_sop=(idx==0), out_eop=(idx==FRAME_LEN-1), out_valid=1.
  - idx increments and wraps to 0 after FRAME_LEN-1.
  - If ld=1 and there is no input, out_valid drops to 0.
- State PAD:
  - in_ready=0 and pad_active=1.
  - On each ld, emit out_data=0, out_valid=1, out_sop=0, out_eop=(idx==FRAME_LEN-1), then idx increments.
  - After loading the eop pad word, idx=0 and state returns to STREAM.
- Flush handling:
  - Flush is sampled only in STREAM. Flush in PAD is ignored.
  - Flush with idx==0 (frame boundary, nothing partial) is ignored.
  - Flush simultaneous with an accepted sample: the sample is accepted first. If that sample was eop, the flush is absorbed (no pad). Otherwise the block enters PAD with the incremented idx.
  - Flush while out_valid=1 and out_ready=0 still enters PAD. Pad words wait on backpressure.
- Exactly FRAME_LEN words are emitted between sop and eop, inclusive, in all cases.
- A sop is never emitted from PAD.
- Back-to-back frames sustain 1 sample per clock when out_ready=1 and in_valid=1.
- No arithmetic is performed on data. idx is IDX_WIDTH bits and compares with FRAME_LEN-1 without truncation.

Optional Feature:
- Macro FFT_FRAME_PACKETIZER_FRAME_CNT_EN.
- Defined: adds output port frame_count [15:0], reset to 0.
  - Increments by 1 on each out_eop word accepted downstream (out_valid && out_ready && out_eop).
  - Wraps 0xFFFF→0x0000.
  - Counts padded frames the same as full frames.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Full frame: FRAME_LEN=64, in_data=0..63 continuous, out_ready=1 → out_data=0..63 one cycle later; sop on word 0 and eop on word 63 only; a second frame 64..127 follows with no bubble.
- Partial flush: accept 10 samples (data 1..10), pulse flush → in_ready=0 for 54 accepted output words; out_data 1..10 then 54 zeros; eop on the 64th word; pad_active high throughout; in_ready returns to 1 the cycle after eop loads.
- Flush edge cases:
  - Flush at idx==0 → no pad, pad_active stays 0.
  - Flush coincident with the 64th accepted sample → that sample carries eop, no pad follows.
  - Flush coincident with the 5th sample → 5 data words, 59 pads.
- Backpressure: toggle out_ready pseudo-randomly during both data and pad → out_data/sop/eop are held stable while stalled; the word sequence is identical to the out_ready=1 run; no words are dropped or duplicated.
- Reset mid-frame: reset_n=0 for 1 cycle after 20 samples → out_valid=0 the next cycle; the next sample emitted has sop=1; no eop appears for the aborted frame.
- With FFT_FRAME_PACKETIZER_FRAME_CNT_EN: 3 full frames plus 1 flushed frame → frame_count=4. Preload 0xFFFF via 65535 frames (or force) plus 1 more → frame_count=0.

Source files
------------

// File: rtl/fft_frame_packetizer.sv
// fft_frame_packetizer: frames a raw valid/ready sample stream into FRAME_LEN-sample Avalon-ST packets, zero-padding on flush.
// Ports: clk, reset_n (sync, active-low); in_valid/in_ready/in_data sink from FIFO;
//        out_valid/out_ready/out_data/out_sop/out_eop source to FFT core;
//        flush closes a partial frame; pad_active is high while pad words are generated.
// Option: define FFT_FRAME_PACKETIZER_FRAME_CNT_EN to add frame_count[15:0], counting eop words accepted downstream.
module fft_frame_packetizer #(
    parameter int DATA_WIDTH = 36,
    parameter int FRAME_LEN  = 64,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  flush,
    output logic                  pad_active
`ifdef FFT_FRAME_PACKETIZER_FRAME_CNT_EN
   ,output logic [15:0]           frame_count
`endif
);
    typedef enum logic {STREAM, PAD} state_t;
    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic                  ld, last, acc;
    // The output register may be reloaded when empty or when its word is taken this cycle.
    assign ld         = !vld_q || out_ready;
    // Compare at integer width so FRAME_LEN == 2**IDX_WIDTH is handled without truncation.
    assign last       = int'(idx_q) == FRAME_LEN - 1;
    assign in_ready   = (state_q == STREAM) && ld;
    assign acc        = in_valid && in_ready;
    assign pad_active = state_q == PAD;
    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign out_sop    = sop_q;
    assign out_eop    = eop_q;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (state_q == STREAM) begin
            if (acc) begin
                vld_d   = 1'b1;
                data_d  = in_data;
                sop_d   = idx_q == '0;
                eop_d   = last;
                idx_d   = last ? '0 : idx_q + 1'b1;
                // A flush arriving with the eop sample is absorbed: the frame is already complete.
                state_d = (flush && !last) ? PAD : STREAM;
            end else begin
                vld_d   = ld ? 1'b0 : vld_q;
                state_d = (flush && idx_q != '0) ? PAD : STREAM;
            end
        end else if (ld) begin
            vld_d   = 1'b1;
            data_d  = '0;
            sop_d   = 1'b0;
            eop_d   = last;
            idx_d   = last ? '0 : idx_q + 1'b1;
            state_d = last ? STREAM : PAD;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= STREAM;
            idx_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end
`ifdef FFT_FRAME_PACKETIZER_FRAME_CNT_EN
    logic [15:0] fc_q;
    always_ff @(posedge clk) begin
        if (!reset_n)
            fc_q <= '0;
        else if (vld_q && out_ready && eop_q)
            fc_q <= fc_q + 16'd1;
    end
    assign frame_count = fc_q;
`endif
endmodule
